writeback_rf: RTL and testbench
===============================

WRITEBACK_RF -- requirements
Module: writeback_rf

Interface
REQ-001 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset; the only reset.
REQ-003 SHALL have port x_wb_regdest  input  5  destination register from the X pipe.
REQ-004 SHALL have port x_wb_writereg  input  1  X-pipe write request; X pipe has no backpressure.
REQ-005 SHALL have port x_wb_wbvalue  input  32  X-pipe result.
REQ-006 SHALL have port m_wb_regdest  input  5  destination register from the M (memory) pipe.
REQ-007 SHALL have port m_wb_writereg  input  1  M-pipe write request.
REQ-008 SHALL have port m_wb_wbvalue  input  32  M-pipe result.
REQ-009 SHALL have port wb_m_stall  output  1  M pipe holds its outputs while high.
REQ-010 SHALL have ports is_wb_rs, is_wb_rt  input  5 each  issue-stage read addresses.
REQ-011 SHALL have ports wb_is_rega, wb_is_regb  output  32 each  read data for rs and rt.
REQ-012 SHALL have port wb_is_retire  output  1  a register write completed last cycle.
REQ-013 SHALL have port wb_is_retire_reg  output  5  register index of that write; used by the issue scoreboard to clear the busy bit.

Function
REQ-014 SHALL hold 32 x 32-bit registers; r0 reads 0 and is never written.
REQ-015 SHALL perform at most one register write per cycle.
REQ-016 SHALL grant the write port with fixed priority: X request, then FIFO head, then direct M request.
REQ-017 SHALL enqueue an accepted M request into a 2-entry FIFO when it does not win the port (regdest, value).
REQ-018 SHALL write an accepted M request in the same cycle, bypassing the FIFO, when X is idle and the FIFO is empty.
REQ-019 SHALL accept an M request only when m_wb_writereg=1 and wb_m_stall=0; M inputs are ignored while stalled.
REQ-020 SHALL drive wb_m_stall combinationally as (FIFO count == 2).
REQ-021 SHALL keep the FIFO count unchanged on a simultaneous dequeue and enqueue; it SHALL never overflow or underflow.
REQ-022 SHALL drop any request with regdest 0: no register write, no retire, and no FIFO entry.
REQ-023 SHALL produce combinational, asynchronous register reads.
REQ-024 SHALL bypass a same-cycle write to a read port: if the read address equals the nonzero register being written this cycle, the port returns the write data.
REQ-025 SHALL register wb_is_retire and wb_is_retire_reg so they reflect the write of the previous cycle; when no write occurred, retire=0 and retire_reg=0.
REQ-026 SHALL preserve M-pipe write order through the FIFO (in-order dequeue).
REQ-027 SHALL rely on the issue scoreboard to prevent WAW hazards between in-flight X and M writes; no ordering between X and M is enforced.

Reset
REQ-028 SHALL, while reset=0, clear all 32 registers, empty the FIFO, and drive wb_m_stall=0, wb_is_retire=0 and wb_is_retire_reg=0.
REQ-029 SHALL discard queued FIFO entries on reset mid-operation; no write completes in the reset cycle.
REQ-030 SHALL resume normal operation on the first rising clock edge after reset deasserts.

Structure
REQ-031 SHALL place the following constants in a shared package: register count 32, data width 32, register-address width 5, FIFO depth 2.
REQ-032 SHALL implement the FIFO as a sub-module wb_fifo with push, pop, head data, count, and full signals.
REQ-033 SHALL keep the register array, priority mux, read bypass and retire registers in writeback_rf.

Verification
REQ-034 Scenario: X writes r5=0x1234_5678 while rs=5 -> wb_is_rega=0x1234_5678 in the same cycle; next cycle retire=1, retire_reg=5.
REQ-035 Scenario: X r3=0xA and M r4=0xB in the same cycle -> r3 written in cycle 0 and r4 in cycle 1; retire_reg sequence 3, 4.
REQ-036 Scenario: X active continuously while M issues r7, r8, r9 -> wb_m_stall=1 after two enqueues; r9 held; once X idles, writes occur in order r7, r8, r9.
REQ-037 Scenario: request to r0 with value 0xFFFF_FFFF from either pipe -> r0 still reads 0; retire=0.
REQ-038 Scenario: reset=0 asserted with 2 FIFO entries queued -> FIFO empty, stall=0, all registers read 0, retire=0.
REQ-039 Scenario: M-only request r10=0x55 with FIFO empty -> direct write, no enqueue; r10 reads 0x55 in that cycle via bypass; retire next cycle.

Source files
------------

// File: rtl/writeback_rf_pkg.sv
// -----------------------------------------------------------------------------
// writeback_rf_pkg
// Shared constants and types for the writeback / register-file slice.
//   NUM_REGS    : architectural register count
//   DATA_W      : register / result width
//   ADDR_W      : register-address width
//   FIFO_DEPTH  : M-pipe skid FIFO depth
// -----------------------------------------------------------------------------
package writeback_rf_pkg;

    localparam int NUM_REGS   = 32;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

    typedef logic [ADDR_W-1:0]     reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;
    typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;
    typedef logic [FIFO_PTR_W-1:0] fifo_ptr_t;

    // One pending register write.
    typedef struct packed {
        reg_addr_t regdest;
        reg_data_t value;
    } wb_req_t;

    // Which source owns the single write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_X,
        SRC_FIFO,
        SRC_M
    } wb_src_e;

    // r0 is hardwired to zero, so a request targeting it carries no work.
    function automatic logic is_live_dest(input reg_addr_t addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/writeback_rf_if.sv
// -----------------------------------------------------------------------------
// writeback_rf_if
// M-pipe -> writeback handshake.
//   m_wb_regdest  : destination register
//   m_wb_writereg : write request
//   m_wb_wbvalue  : result value
//   wb_m_stall    : writeback cannot accept; M pipe holds its outputs
// Modports: master = M pipe, slave = writeback stage.
// -----------------------------------------------------------------------------
interface writeback_rf_if;
    import writeback_rf_pkg::*;

    reg_addr_t m_wb_regdest;
    logic      m_wb_writereg;
    reg_data_t m_wb_wbvalue;
    logic      wb_m_stall;

    modport master (
        output m_wb_regdest,
        output m_wb_writereg,
        output m_wb_wbvalue,
        input  wb_m_stall
    );

    modport slave (
        input  m_wb_regdest,
        input  m_wb_writereg,
        input  m_wb_wbvalue,
        output wb_m_stall
    );

endinterface

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small in-order FIFO holding M-pipe writes that lost the write port.
//   clock, reset : clock, async active-low reset (empties the FIFO)
//   push, push_data : enqueue (ignored when full)
//   pop          : dequeue head (ignored when empty)
//   head         : current head entry (valid when count != 0)
//   count, full  : occupancy, count == FIFO_DEPTH
// -----------------------------------------------------------------------------
module wb_fifo
    import writeback_rf_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  wb_req_t   push_data,
    input  logic      pop,
    output wb_req_t   head,
    output fifo_cnt_t count,
    output logic      full
);

    wb_req_t   mem [FIFO_DEPTH];
    fifo_ptr_t wr_ptr;
    fifo_ptr_t rd_ptr;
    logic      push_ok;
    logic      pop_ok;

    assign full    = (count == fifo_cnt_t'(FIFO_DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap naturally.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + fifo_ptr_t'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + fifo_ptr_t'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + fifo_cnt_t'(1);
                2'b01:   count <= count - fifo_cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage has no reset; an entry is only read after a push
    // has written it, and the empty state is carried by count alone.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/writeback_rf.sv
// -----------------------------------------------------------------------------
// writeback_rf
// 32x32 register file with a single write port shared by the X pipe (no
// backpressure) and the M pipe (stallable, buffered by a 2-entry FIFO).
//   clock, reset               : clock, async active-low reset
//   x_wb_regdest/writereg/wbvalue : X-pipe write request
//   m_bus (slave)              : M-pipe request + wb_m_stall
//   is_wb_rs, is_wb_rt         : issue-stage read addresses
//   wb_is_rega, wb_is_regb     : read data with same-cycle write bypass
//   wb_is_retire(_reg)         : registered report of last cycle's write
// -----------------------------------------------------------------------------
module writeback_rf
    import writeback_rf_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  reg_addr_t          x_wb_regdest,
    input  logic               x_wb_writereg,
    input  reg_data_t          x_wb_wbvalue,
    writeback_rf_if.slave      m_bus,
    input  reg_addr_t          is_wb_rs,
    input  reg_addr_t          is_wb_rt,
    output reg_data_t          wb_is_rega,
    output reg_data_t          wb_is_regb,
    output logic               wb_is_retire,
    output reg_addr_t          wb_is_retire_reg
);

    reg_data_t regs [NUM_REGS];

    logic      x_req;
    logic      m_acc;
    logic      fifo_push;
    logic      fifo_pop;
    logic      fifo_full;
    fifo_cnt_t fifo_count;
    wb_req_t   fifo_head;
    wb_src_e   src;
    logic      we;
    reg_addr_t waddr;
    reg_data_t wdata;

    // Requests to r0 are dropped up front so they never reach the port or FIFO.
    assign x_req = x_wb_writereg && is_live_dest(x_wb_regdest);
    assign m_acc = m_bus.m_wb_writereg && !fifo_full && is_live_dest(m_bus.m_wb_regdest);

    assign m_bus.wb_m_stall = fifo_full;

    wb_fifo u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ('{regdest: m_bus.m_wb_regdest, value: m_bus.m_wb_wbvalue}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    // Fixed priority: X, then FIFO head, then a direct M write. An accepted M
    // request that loses the port is queued behind anything already waiting.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        src       = SRC_NONE;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (x_req) begin
            src       = SRC_X;
            fifo_push = m_acc;
        end else if (fifo_count != '0) begin
            src       = SRC_FIFO;
            fifo_pop  = 1'b1;
            fifo_push = m_acc;
        end else if (m_acc) begin
            src       = SRC_M;
        end
    end

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        unique case (src)
            SRC_X: begin
                we    = 1'b1;
                waddr = x_wb_regdest;
                wdata = x_wb_wbvalue;
            end
            SRC_FIFO: begin
                we    = 1'b1;
                waddr = fifo_head.regdest;
                wdata = fifo_head.value;
            end
            SRC_M: begin
                we    = 1'b1;
                waddr = m_bus.m_wb_regdest;
                wdata = m_bus.m_wb_wbvalue;
            end
            default: ;
        endcase
    end

    // The array is cleared on reset because software-visible state must read
    // zero afterwards. r0 is never written, so it stays zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Bypass the in-flight write so issue sees it in the same cycle.
    // we implies waddr != 0, so r0 can never be bypassed.
    assign wb_is_rega = (is_wb_rs == '0)              ? '0    :
                        (we && (waddr == is_wb_rs))   ? wdata : regs[is_wb_rs];
    assign wb_is_regb = (is_wb_rt == '0)              ? '0    :
                        (we && (waddr == is_wb_rt))   ? wdata : regs[is_wb_rt];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_is_retire     <= 1'b0;
            wb_is_retire_reg <= '0;
        end else begin
            wb_is_retire     <= we;
            wb_is_retire_reg <= we ? waddr : '0;
        end
    end

endmodule

// File: tb/tb_writeback_rf.sv
// -----------------------------------------------------------------------------
// tb_writeback_rf
// Directed stimulus for writeback_rf. Expected retire order is queued when the
// stimulus is issued; a monitor pops and compares on every reported retire.
// Read-port, stall and reset values are compared directly against constants.
// -----------------------------------------------------------------------------
module tb_writeback_rf;
    import writeback_rf_pkg::*;

    logic      clock;
    logic      reset;
    reg_addr_t x_wb_regdest;
    logic      x_wb_writereg;
    reg_data_t x_wb_wbvalue;
    reg_addr_t is_wb_rs;
    reg_addr_t is_wb_rt;
    reg_data_t wb_is_rega;
    reg_data_t wb_is_regb;
    logic      wb_is_retire;
    reg_addr_t wb_is_retire_reg;

    writeback_rf_if m_if ();

    writeback_rf dut (
        .clock            (clock),
        .reset            (reset),
        .x_wb_regdest     (x_wb_regdest),
        .x_wb_writereg    (x_wb_writereg),
        .x_wb_wbvalue     (x_wb_wbvalue),
        .m_bus            (m_if),
        .is_wb_rs         (is_wb_rs),
        .is_wb_rt         (is_wb_rt),
        .wb_is_rega       (wb_is_rega),
        .wb_is_regb       (wb_is_regb),
        .wb_is_retire     (wb_is_retire),
        .wb_is_retire_reg (wb_is_retire_reg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int        total = 0;
    int        bad   = 0;
    reg_addr_t exp_q[$];
    reg_addr_t mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: outputs are sampled on the falling edge.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (wb_is_retire) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL retire_unexpected: got reg %0d want no retire", wb_is_retire_reg);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("retire_reg", 32'(wb_is_retire_reg), 32'(mon_exp));
                end
            end else begin
                check("retire_reg_idle", 32'(wb_is_retire_reg), 32'd0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_x(input reg_addr_t d, input logic v, input reg_data_t val);
        x_wb_regdest  = d;
        x_wb_writereg = v;
        x_wb_wbvalue  = val;
    endtask

    task automatic drive_m(input reg_addr_t d, input logic v, input reg_data_t val);
        m_if.m_wb_regdest  = d;
        m_if.m_wb_writereg = v;
        m_if.m_wb_wbvalue  = val;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_x('0, 1'b0, '0);
        drive_m('0, 1'b0, '0);
        is_wb_rs = 5'd5;
        is_wb_rt = 5'd0;
        reset    = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        check("reset_stall", 32'(m_if.wb_m_stall), 32'd0);
        check("reset_retire", 32'(wb_is_retire), 32'd0);
        check("reset_retire_reg", 32'(wb_is_retire_reg), 32'd0);
        check("reset_r5", wb_is_rega, 32'd0);
        #1 reset = 1'b1;

        // X write with same-cycle read bypass
        next_cycle();
        drive_x(5'd5, 1'b1, 32'h1234_5678);
        exp_q.push_back(5'd5);
        @(negedge clock);
        check("x_bypass_r5", wb_is_rega, 32'h1234_5678);
        next_cycle();
        drive_x('0, 1'b0, '0);
        @(negedge clock);
        check("x_r5_stored", wb_is_rega, 32'h1234_5678);

        // X and M collide: X first, M one cycle later from the FIFO
        next_cycle();
        drive_x(5'd3, 1'b1, 32'h0000_000A);
        drive_m(5'd4, 1'b1, 32'h0000_000B);
        is_wb_rs = 5'd3;
        is_wb_rt = 5'd4;
        exp_q.push_back(5'd3);
        exp_q.push_back(5'd4);
        @(negedge clock);
        check("collide_r3_bypass", wb_is_rega, 32'h0000_000A);
        check("collide_r4_not_yet", wb_is_regb, 32'd0);
        check("collide_stall", 32'(m_if.wb_m_stall), 32'd0);
        next_cycle();
        drive_x('0, 1'b0, '0);
        drive_m('0, 1'b0, '0);
        @(negedge clock);
        check("collide_r4_bypass", wb_is_regb, 32'h0000_000B);
        check("collide_r3_stored", wb_is_rega, 32'h0000_000A);
        next_cycle();
        @(negedge clock);

        // X busy while M streams r7, r8, r9: FIFO fills and stalls
        exp_q.push_back(5'd11);
        exp_q.push_back(5'd12);
        exp_q.push_back(5'd13);
        exp_q.push_back(5'd7);
        exp_q.push_back(5'd8);
        exp_q.push_back(5'd9);
        next_cycle();
        drive_x(5'd11, 1'b1, 32'd1);
        drive_m(5'd7, 1'b1, 32'h70);
        @(negedge clock);
        check("stream_stall_c1", 32'(m_if.wb_m_stall), 32'd0);
        next_cycle();
        drive_x(5'd12, 1'b1, 32'd2);
        drive_m(5'd8, 1'b1, 32'h80);
        @(negedge clock);
        check("stream_stall_c2", 32'(m_if.wb_m_stall), 32'd0);
        next_cycle();
        drive_x(5'd13, 1'b1, 32'd3);
        drive_m(5'd9, 1'b1, 32'h90);
        @(negedge clock);
        check("stream_stall_full", 32'(m_if.wb_m_stall), 32'd1);
        next_cycle();
        drive_x('0, 1'b0, '0);
        is_wb_rs = 5'd7;
        @(negedge clock);
        check("stream_stall_drain", 32'(m_if.wb_m_stall), 32'd1);
        check("stream_r7_bypass", wb_is_rega, 32'h70);
        next_cycle();
        is_wb_rs = 5'd8;
        @(negedge clock);
        check("stream_stall_release", 32'(m_if.wb_m_stall), 32'd0);
        check("stream_r8_bypass", wb_is_rega, 32'h80);
        next_cycle();
        drive_m('0, 1'b0, '0);
        is_wb_rs = 5'd9;
        @(negedge clock);
        check("stream_r9_bypass", wb_is_rega, 32'h90);
        next_cycle();
        is_wb_rs = 5'd7;
        is_wb_rt = 5'd8;
        @(negedge clock);
        check("stream_r7_stored", wb_is_rega, 32'h70);
        check("stream_r8_stored", wb_is_regb, 32'h80);

        // r0 requests are dropped from either pipe
        next_cycle();
        drive_x(5'd0, 1'b1, 32'hFFFF_FFFF);
        is_wb_rs = 5'd0;
        is_wb_rt = 5'd0;
        @(negedge clock);
        check("r0_x_read", wb_is_rega, 32'd0);
        next_cycle();
        drive_x('0, 1'b0, '0);
        drive_m(5'd0, 1'b1, 32'hFFFF_FFFF);
        @(negedge clock);
        check("r0_m_read", wb_is_regb, 32'd0);
        check("r0_x_no_retire", 32'(wb_is_retire), 32'd0);
        next_cycle();
        drive_m('0, 1'b0, '0);
        @(negedge clock);
        check("r0_m_no_retire", 32'(wb_is_retire), 32'd0);
        check("r0_m_no_enqueue", 32'(m_if.wb_m_stall), 32'd0);

        // M-only write with empty FIFO goes straight to the array
        next_cycle();
        drive_m(5'd10, 1'b1, 32'h55);
        is_wb_rs = 5'd10;
        exp_q.push_back(5'd10);
        @(negedge clock);
        check("m_direct_bypass", wb_is_rega, 32'h55);
        check("m_direct_stall", 32'(m_if.wb_m_stall), 32'd0);
        next_cycle();
        drive_m('0, 1'b0, '0);
        @(negedge clock);
        check("m_direct_stored", wb_is_rega, 32'h55);
        next_cycle();
        @(negedge clock);

        // Reset with two queued FIFO entries
        exp_q.push_back(5'd14);
        exp_q.push_back(5'd16);
        next_cycle();
        drive_x(5'd14, 1'b1, 32'hE);
        drive_m(5'd15, 1'b1, 32'hF);
        @(negedge clock);
        next_cycle();
        drive_x(5'd16, 1'b1, 32'h10);
        drive_m(5'd17, 1'b1, 32'h11);
        @(negedge clock);
        next_cycle();
        drive_x('0, 1'b0, '0);
        drive_m('0, 1'b0, '0);
        @(negedge clock);
        check("prereset_stall", 32'(m_if.wb_m_stall), 32'd1);
        #1 reset = 1'b0;
        @(negedge clock);
        check("midreset_stall", 32'(m_if.wb_m_stall), 32'd0);
        check("midreset_retire", 32'(wb_is_retire), 32'd0);
        check("midreset_retire_reg", 32'(wb_is_retire_reg), 32'd0);
        for (int i = 1; i < NUM_REGS; i++) begin
            is_wb_rs = reg_addr_t'(i);
            #1;
            check($sformatf("midreset_r%0d", i), wb_is_rega, 32'd0);
        end
        #1 reset = 1'b1;
        next_cycle();
        @(negedge clock);
        check("postreset_stall", 32'(m_if.wb_m_stall), 32'd0);
        next_cycle();
        @(negedge clock);

        // Normal operation resumes after reset
        next_cycle();
        drive_x(5'd20, 1'b1, 32'h0000_BEEF);
        is_wb_rs = 5'd20;
        is_wb_rt = 5'd15;
        exp_q.push_back(5'd20);
        @(negedge clock);
        check("resume_bypass", wb_is_rega, 32'h0000_BEEF);
        next_cycle();
        drive_x('0, 1'b0, '0);
        @(negedge clock);
        check("resume_stored", wb_is_rega, 32'h0000_BEEF);
        check("resume_r15_dropped", wb_is_regb, 32'd0);

        repeat (2) @(negedge clock);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
